// File: rtl/window_accumulator.sv
// Moving-window accumulator: registered signed sum of the last DEPTH +/-X contributions.
// Optional rounded average output enabled by defining WINDOW_ACCUMULATOR_AVG_EN.
module window_accumulator #(
    parameter int unsigned N     = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned G    = $clog2(DEPTH),
    localparam int unsigned W    = N + 1 + G
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 load,
    input  logic                 add_n,
    input  logic signed [N-1:0]  X,
    output logic signed [W-1:0]  Q,
`ifdef WINDOW_ACCUMULATOR_AVG_EN
    output logic signed [N:0]    avg,
`endif
    output logic                 q_valid,
    output logic                 primed
);

    localparam int unsigned PW = G;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic signed [N:0]   ring_q [DEPTH];
    logic signed [W-1:0] sum_q, sum_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic signed [N:0]   xs, contrib, evict;
    logic                accept;

    assign accept = load && !clear;

    always_comb begin
        xs      = {X[N-1], X};
        // N+1 bits make the negation of the most negative sample exact.
        contrib = add_n ? -xs : xs;
        evict   = ring_q[ptr_q];
        sum_d   = sum_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        if (clear) begin
            sum_d = '0;
            ptr_d = '0;
            cnt_d = '0;
        end else if (load) begin
            sum_d   = sum_q + {{G{contrib[N]}}, contrib} - {{G{evict[N]}}, evict};
            ptr_d   = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
            cnt_d   = (cnt_q == CW'(DEPTH)) ? cnt_q : cnt_q + 1'b1;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) ring_q[i] <= '0;
        end else begin
            sum_q   <= sum_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            if (clear) begin
                for (int i = 0; i < int'(DEPTH); i++) ring_q[i] <= '0;
            end else if (accept) begin
                ring_q[ptr_q] <= contrib;
            end
        end
    end

    assign Q       = sum_q;
    assign q_valid = valid_q;
    assign primed  = (cnt_q == CW'(DEPTH));

`ifdef WINDOW_ACCUMULATOR_AVG_EN
    if ((DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("window_accumulator: DEPTH must be a power of 2 when avg is enabled");
    end

    logic signed [W-1:0] rnd;
    logic signed [N:0]   avg_q, avg_d;

    // Round half up, then keep the upper N+1 bits (arithmetic shift by G).
    assign rnd = sum_d + W'(2 ** (G - 1));

    always_comb begin
        avg_d = avg_q;
        if (clear) begin
            avg_d = '0;
        end else if (load) begin
            avg_d = rnd[W-1:G];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avg_q <= '0;
        end else begin
            avg_q <= avg_d;
        end
    end

    assign avg = avg_q;
`endif

endmodule

// File: tb/tb_window_accumulator.sv
// Randomized self-checking bench: two instances (DEPTH 4 and a second depth) against a
// queue-based reference model of the window sum.
module tb_window_accumulator;

    localparam int NA = 8;
    localparam int DA = 4;
    localparam int GA = $clog2(DA);
    localparam int WA = NA + 1 + GA;
`ifdef WINDOW_ACCUMULATOR_AVG_EN
    localparam int DB = 8;
`else
    localparam int DB = 5;
`endif
    localparam int GB = $clog2(DB);
    localparam int WB = NA + 1 + GB;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clear = 1'b0;
    logic load = 1'b0;
    logic add_n = 1'b0;
    logic signed [NA-1:0] x_in = '0;
    logic signed [WA-1:0] qa;
    logic signed [WB-1:0] qb;
    logic vld_a, vld_b, prm_a, prm_b;
`ifdef WINDOW_ACCUMULATOR_AVG_EN
    logic signed [NA:0] avg_a, avg_b;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int win_a[$];
    int win_b[$];
    int exp_vld = 0;

    always #5 clk = ~clk;

    window_accumulator #(.N(NA), .DEPTH(DA)) u_dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .load    (load),
        .add_n   (add_n),
        .X       (x_in),
        .Q       (qa),
`ifdef WINDOW_ACCUMULATOR_AVG_EN
        .avg     (avg_a),
`endif
        .q_valid (vld_a),
        .primed  (prm_a)
    );

    window_accumulator #(.N(NA), .DEPTH(DB)) u_dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .load    (load),
        .add_n   (add_n),
        .X       (x_in),
        .Q       (qb),
`ifdef WINDOW_ACCUMULATOR_AVG_EN
        .avg     (avg_b),
`endif
        .q_valid (vld_b),
        .primed  (prm_b)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sum_a();
        int s = 0;
        foreach (win_a[i]) s += win_a[i];
        return s;
    endfunction

    function automatic int sum_b();
        int s = 0;
        foreach (win_b[i]) s += win_b[i];
        return s;
    endfunction

    task automatic model_reset();
        win_a.delete();
        win_b.delete();
        exp_vld = 0;
    endtask

    task automatic model_step(input bit clr, input bit ld, input bit an, input int x);
        int c;
        if (clr) begin
            model_reset();
        end else if (ld) begin
            c = an ? -x : x;
            win_a.push_back(c);
            if (win_a.size() > DA) void'(win_a.pop_front());
            win_b.push_back(c);
            if (win_b.size() > DB) void'(win_b.pop_front());
            exp_vld = 1;
        end else begin
            exp_vld = 0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".Qa"}, int'(qa), sum_a());
        check({tag, ".Qb"}, int'(qb), sum_b());
        check({tag, ".vld_a"}, int'(vld_a), exp_vld);
        check({tag, ".vld_b"}, int'(vld_b), exp_vld);
        check({tag, ".prm_a"}, int'(prm_a), int'(win_a.size() == DA));
        check({tag, ".prm_b"}, int'(prm_b), int'(win_b.size() == DB));
`ifdef WINDOW_ACCUMULATOR_AVG_EN
        check({tag, ".avg_a"}, int'(avg_a), (sum_a() + (1 << (GA - 1))) >>> GA);
        check({tag, ".avg_b"}, int'(avg_b), (sum_b() + (1 << (GB - 1))) >>> GB);
`endif
    endtask

    // Present inputs, take one edge, update the model and compare just after the edge.
    task automatic step(input string tag, input bit clr, input bit ld, input bit an,
                        input int x);
        clear = clr;
        load  = ld;
        add_n = an;
        x_in  = NA'(x);
        @(posedge clk);
        model_step(clr, ld, an, x);
        #1;
        check_all(tag);
    endtask

    initial begin
        int x;
        bit ld, clr, an;

        repeat (3) @(posedge clk);
        #1;
        model_reset();
        check_all("reset");
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) step("idle0", 0, 0, 0, 0);

        for (int i = 1; i <= 4; i++) step("fill", 0, 1, 0, i);
        check("fill.Qa10", int'(qa), 10);
        step("slide", 0, 1, 0, 5);
        check("slide.Qa14", int'(qa), 14);
        step("idle1", 0, 0, 0, 0);
        step("idle2", 0, 0, 0, 0);

        step("neg10", 0, 1, 1, 10);
        check("neg10.Qa2", int'(qa), 2);
        for (int i = 0; i < 3; i++) step("zero", 0, 1, 0, 0);
        check("mixed.Qa_m10", int'(qa), -10);

        for (int i = 0; i < 4; i++) step("negmin", 0, 1, 1, -128);
        check("negmin.Qa512", int'(qa), 512);
        for (int i = 0; i < 4; i++) step("posmin", 0, 1, 0, -128);
        check("posmin.Qa_m512", int'(qa), -512);
        for (int i = 0; i < 4; i++) step("flush", 0, 1, 0, 0);

        for (int i = 0; i < 5; i++) step("prime", 0, 1, 0, 3);
        step("clrprio", 1, 1, 0, 9);
        check("clrprio.Qa0", int'(qa), 0);
        step("after_clr", 0, 1, 0, 7);
        check("after_clr.Qa7", int'(qa), 7);

        step("clr2", 1, 0, 0, 0);
        for (int i = 1; i <= 7; i++) step("ones", 0, 1, 0, 1);

        // Asynchronous reset between edges must clear outputs without a clock edge.
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        #1;

        for (int i = 0; i < 600; i++) begin
            clr = ($urandom_range(0, 39) == 0);
            ld  = ($urandom_range(0, 9) < 7);
            an  = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 7))
                0:       x = -128;
                1:       x = 127;
                default: x = int'($urandom_range(0, 255)) - 128;
            endcase
            step("rand", clr, ld, an, x);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
